clk_div_bank: RTL and testbench
===============================

// Module: clk_div_bank
// PURPOSE
//  Parametrised bank of NCH programmable clock-enable generators driven by the 200 MHz board clock.
//  Each channel emits a 1-cycle tick every DIV cycles and a divided square wave.
//  The square wave is a data signal, never a clock net.
//  Consumers are slow peripherals (7-seg scan, PS/2, UART baud, LED blink).
//  Adds a startup hold-off and glitch-free runtime ratio changes through a valid/ready config port.
// PARAMETERS
//  NCH      4     number of channels
//  DIV_W    16    divider width; max ratio 2^DIV_W-1
//  STARTUP  1024  cycles after reset release before any channel runs (>=1)
//  DEF_DIV  2     per-channel ratio loaded at reset
// PORTS
//  clk        in   1               200 MHz system clock; single clock domain
//  rst_n      in   1               asynchronous reset, active-low
//  ch_enable  in   NCH             per-channel run mask
//  cfg_valid  in   1               config request
//  cfg_ready  out  1               config accept; transfer on cfg_valid & cfg_ready
//  cfg_ch     in   $clog2(NCH)+1   target channel index
//  cfg_div    in   DIV_W           new ratio
//  cfg_err    out  1               1-cycle pulse: cfg_ch >= NCH
//  ready      out  1               startup complete
//  tick       out  NCH             1-cycle enable pulse per channel
//  clk_out    out  NCH             divided square wave, period 2*DIV
// BEHAVIOUR
//  Reset (async): ready=0, tick=0, clk_out=0, cfg_err=0, cfg_ready=0, pending dropped, all DIV=DEF_DIV.
//  Startup: counter runs 0..STARTUP-1; ready goes to 1 registered, STARTUP cycles after rst_n rises.
//   cfg_ready=0 and all channels held idle until ready=1.
//  Ratio rule: effective d = (DIV<2) ? 1 : DIV.
//  Channel counter cnt: 0..d-1, wraps at d-1.
//   tick is registered; high for exactly one cycle when cnt wraps, so ticks are d cycles apart.
//   d=1 gives tick permanently high. clk_out toggles in the cycle tick is high.
//  Channel run condition: ready & ch_enable[i]. While not running: cnt=0, tick=0, clk_out=0 from the next cycle.
//   First tick after (re)start comes d cycles after the run condition rises.
//  Config: one-entry pending register {ch, div}, shared by the bank.
//   cfg_ready = ready & pending empty. Accepted cfg_ch >= NCH: discarded, cfg_err pulses the next cycle, cfg_ready stays 1.
//   Apply point is the target channel's wrap cycle: the tick of that cycle uses the old d; the next period uses the new d.
//   If the target channel is not running, the update applies the cycle after acceptance.
//   Pending is cleared in the apply cycle; cfg_ready returns to 1 the following cycle.
//   New config therefore never coincides with an apply.
//  Ratio change to the current value follows the same pending/apply path; no tick is skipped or duplicated.
//  Reset mid-operation: all state is cleared immediately, including any pending update.
//   The startup hold-off is re-run in full.
//  All arithmetic is unsigned DIV_W-bit; cnt never exceeds d-1 (compare with ==, no overflow path).
// STRUCTURE
//  clk_div_pkg: DIV_W default, DEF_DIV, STARTUP default, cfg request struct {ch, div}.
//  Sub-module clk_div_chan (one per channel, generate loop).
//   Inputs: run, load strobe, new div.
//   Holds: cnt, div register, tick, clk_out.
//   Output: wrap flag, used by the top to time the apply point.
//  Top holds: startup counter, pending register, handshake logic, cfg_err.
// TESTING
//  1 STARTUP=16, all ch_enable=1 -> ready rises exactly 16 cycles after rst_n; no tick or clk_out activity before.
//  2 ch0 DIV=4 -> tick spacing 4 cycles; clk_out period 8 with 50% duty; first tick 4 cycles after ready.
//  3 ch1 running d=4, cfg 4->6 accepted at cnt=1 -> next tick still 3 cycles later.
//     Subsequent spacing is 6; cfg_ready low from acceptance through the apply cycle.
//  4 cfg_div=0 and =1 on ch2 -> tick constantly high, clk_out toggles every cycle.
//  5 NCH=4, cfg_ch=5 -> one-cycle cfg_err, no channel timing change, cfg_ready stays 1.
//     Also: ch_enable[3]=0 with cfg on ch3 -> applied next cycle; first tick d cycles after enable.
//  6 rst_n low mid-run with a pending update -> tick/clk_out/ready/cfg_ready go to 0 immediately.
//     After release: DIV=DEF_DIV on all channels, startup repeats, pending update lost.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared defaults and the config request record for the clock-enable divider bank.
package clk_div_pkg;

  localparam int NCH_DEF      = 4;
  localparam int DIV_W_DEF    = 16;
  localparam int STARTUP_DEF  = 1024;
  localparam int DEF_DIV_DEF  = 2;
  localparam int CFG_CH_W_DEF = $clog2(NCH_DEF) + 1;

  // Config request at the default bank geometry.
  typedef struct packed {
    logic [CFG_CH_W_DEF-1:0] ch;
    logic [DIV_W_DEF-1:0]    div;
  } cfg_req_t;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: cnt runs 0..d-1, registered tick on wrap, square wave toggled on wrap.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load,
  input  logic [DIV_W-1:0] new_div,
  output logic             wrap,
  output logic             tick,
  output logic             clk_out
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] d_eff;
  logic             tick_q, tick_d;
  logic             clk_out_q, clk_out_d;

  // Ratios 0 and 1 both mean "every cycle".
  assign d_eff = (div_q < DIV_W'(2)) ? DIV_W'(1) : div_q;
  assign wrap  = run & (cnt_q == d_eff - DIV_W'(1));

  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    tick_d    = 1'b0;
    clk_out_d = clk_out_q;
    if (!run) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
    end else if (wrap) begin
      cnt_d     = '0;
      tick_d    = 1'b1;
      clk_out_d = ~clk_out_q;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
    if (load) begin
      div_d = new_div;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_q     <= DIV_W'(DEF_DIV);
      tick_q    <= 1'b0;
      clk_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign tick    = tick_q;
  assign clk_out = clk_out_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of clock-enable dividers with startup hold-off and a one-entry pending ratio update
// that lands on the target channel's wrap so no period is ever cut short or stretched.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NCH     = NCH_DEF,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int STARTUP = STARTUP_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       ch_enable,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [$clog2(NCH):0] cfg_ch,
  input  logic [DIV_W-1:0]     cfg_div,
  output logic                 cfg_err,
  output logic                 ready,
  output logic [NCH-1:0]       tick,
  output logic [NCH-1:0]       clk_out
);

  localparam int CH_W = $clog2(NCH) + 1;
  localparam int ST_W = $clog2(STARTUP + 1);

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [DIV_W-1:0] div;
  } pend_t;

  logic [ST_W-1:0] st_cnt_q, st_cnt_d;
  logic            ready_q, ready_d;
  logic            pend_vld_q, pend_vld_d;
  pend_t           pend_q, pend_d;
  logic            cfg_err_q, cfg_err_d;
  logic [NCH-1:0]  run, wrap, load;
  logic            accept, ch_bad;

  // Hold-off timer counts down; ready is set on the terminal count.
  always_comb begin
    st_cnt_d = st_cnt_q;
    ready_d  = ready_q;
    if (!ready_q) begin
      if (st_cnt_q == '0) begin
        ready_d = 1'b1;
      end else begin
        st_cnt_d = st_cnt_q - ST_W'(1);
      end
    end
  end

  assign run       = ch_enable & {NCH{ready_q}};
  assign cfg_ready = ready_q & ~pend_vld_q;
  assign accept    = cfg_valid & cfg_ready;
  assign ch_bad    = (cfg_ch >= CH_W'(NCH));

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    // An idle target takes the update straight away; a running one waits for its wrap.
    assign load[i] = pend_vld_q & (pend_q.ch == CH_W'(i)) & (wrap[i] | ~run[i]);

    clk_div_chan #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (run[i]),
      .load    (load[i]),
      .new_div (pend_q.div),
      .wrap    (wrap[i]),
      .tick    (tick[i]),
      .clk_out (clk_out[i])
    );
  end

  // accept implies the pending slot is empty, so it never collides with an apply.
  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    cfg_err_d  = accept & ch_bad;
    if (|load) begin
      pend_vld_d = 1'b0;
    end
    if (accept && !ch_bad) begin
      pend_vld_d = 1'b1;
      pend_d.ch  = cfg_ch;
      pend_d.div = cfg_div;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_cnt_q   <= ST_W'(STARTUP - 1);
      ready_q    <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      st_cnt_q   <= st_cnt_d;
      ready_q    <= ready_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign ready   = ready_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomised bench for clk_div_bank: a next-tick-time model feeds an event scoreboard.
`timescale 1ns/100ps
module tb_clk_div_bank;
  import clk_div_pkg::*;

  localparam int NCH     = 4;
  localparam int DIV_W   = 16;
  localparam int STARTUP = 16;
  localparam int DEF_DIV = 2;
  localparam int CH_W    = $clog2(NCH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NCH-1:0]   ch_enable = '1;
  logic             cfg_valid = 1'b0;
  logic [CH_W-1:0]  cfg_ch = '0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic             cfg_ready;
  logic             cfg_err;
  logic             ready;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   clk_out;

  int ntests = 0;
  int nfail  = 0;

  always #2.5 clk = ~clk;

  clk_div_bank #(
    .NCH     (NCH),
    .DIV_W   (DIV_W),
    .STARTUP (STARTUP),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_enable (ch_enable),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_err   (cfg_err),
    .ready     (ready),
    .tick      (tick),
    .clk_out   (clk_out)
  );

  // Expected event: ch 0..NCH-1 tick, NCH cfg_err, NCH+1 ready rising; at = edge index.
  typedef struct {
    int ch;
    int at;
    bit ck;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;

  int  rel;
  bit  m_rdy;
  bit  m_run  [NCH];
  int  m_div  [NCH];
  int  m_nxt  [NCH];
  bit  m_ck   [NCH];
  bit  m_pv;
  int  m_pch;
  int  m_pdiv;

  function automatic int eff(input int d);
    return (d < 2) ? 1 : d;
  endfunction

  task automatic push_ev(input int ch, input int at, input bit ck);
    ev_t e;
    e.ch = ch;
    e.at = at;
    e.ck = ck;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    rel   = 0;
    m_rdy = 1'b0;
    m_pv  = 1'b0;
    m_pch = 0;
    m_pdiv = 0;
    for (int i = 0; i < NCH; i++) begin
      m_run[i] = 1'b0;
      m_div[i] = DEF_DIV;
      m_nxt[i] = 0;
      m_ck[i]  = 1'b0;
    end
    exp_q.delete();
  endtask

  // One clock edge of the reference: a running channel ticks at absolute times
  // start+d-1, then every d edges, re-reading its ratio after each tick.
  task automatic model_step();
    bit prev_rdy;
    bit cfg_rdy;
    bit applied;
    prev_rdy = m_rdy;
    cfg_rdy  = m_rdy && !m_pv;
    applied  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (prev_rdy && ch_enable[i]) begin
        if (!m_run[i]) begin
          m_run[i] = 1'b1;
          m_nxt[i] = cyc + eff(m_div[i]) - 1;
        end
        if (cyc == m_nxt[i]) begin
          m_ck[i] = !m_ck[i];
          push_ev(i, cyc, m_ck[i]);
          if (m_pv && m_pch == i) begin
            m_div[i] = m_pdiv;
            applied  = 1'b1;
          end
          m_nxt[i] = cyc + eff(m_div[i]);
        end
      end else begin
        m_run[i] = 1'b0;
        m_ck[i]  = 1'b0;
        if (m_pv && m_pch == i) begin
          m_div[i] = m_pdiv;
          applied  = 1'b1;
        end
      end
    end
    if (applied) m_pv = 1'b0;
    if (cfg_valid && cfg_rdy) begin
      if (int'(cfg_ch) >= NCH) begin
        push_ev(NCH, cyc, 1'b0);
      end else begin
        m_pv   = 1'b1;
        m_pch  = int'(cfg_ch);
        m_pdiv = int'(cfg_div);
      end
    end
    if (!m_rdy) begin
      rel++;
      if (rel == STARTUP) begin
        m_rdy = 1'b1;
        push_ev(NCH + 1, cyc, 1'b0);
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        cyc++;
        model_step();
      end
    end
  end

  function automatic string ev_name(input int i);
    if (i < NCH) return $sformatf("tick%0d", i);
    if (i == NCH) return "cfg_err";
    return "ready_rise";
  endfunction

  // Monitor: pops the scoreboard whenever the DUT shows an event, flags missing/extra ones.
  initial begin
    bit   rdy_prev;
    logic act;
    bit   hit;
    rdy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ntests++;
        if (tick !== '0 || clk_out !== '0 || ready !== 1'b0 || cfg_ready !== 1'b0 || cfg_err !== 1'b0) begin
          nfail++;
          $display("FAIL reset_state: tick=%b clk_out=%b ready=%b cfg_ready=%b cfg_err=%b, required all zero",
                   tick, clk_out, ready, cfg_ready, cfg_err);
        end
        rdy_prev = 1'b0;
      end else begin
        for (int i = 0; i < NCH + 2; i++) begin
          if (i < NCH) act = tick[i];
          else if (i == NCH) act = cfg_err;
          else act = ready & ~rdy_prev;
          hit = (exp_q.size() > 0) && (exp_q[0].ch == i) && (exp_q[0].at == cyc);
          if (act === 1'b1 || hit) begin
            ntests++;
            if (act === 1'b1 && hit) begin
              if (i < NCH && clk_out[i] !== exp_q[0].ck) begin
                nfail++;
                $display("FAIL clk_out_at_tick ch%0d cycle %0d: got %b, required %b", i, cyc, clk_out[i], exp_q[0].ck);
              end
              void'(exp_q.pop_front());
            end else if (hit) begin
              nfail++;
              $display("FAIL missing_%s cycle %0d: got 0, required 1", ev_name(i), cyc);
              void'(exp_q.pop_front());
            end else begin
              nfail++;
              $display("FAIL unexpected_%s cycle %0d: got %b, required 0", ev_name(i), cyc, act);
            end
          end
        end
        while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
          ntests++;
          nfail++;
          $display("FAIL stale_%s expected at cycle %0d, now %0d: got none, required event", ev_name(exp_q[0].ch), exp_q[0].at, cyc);
          void'(exp_q.pop_front());
        end
        ntests++;
        if (ready !== m_rdy) begin
          nfail++;
          $display("FAIL ready_level cycle %0d: got %b, required %b", cyc, ready, m_rdy);
        end
        ntests++;
        if (cfg_ready !== (m_rdy && !m_pv)) begin
          nfail++;
          $display("FAIL cfg_ready_level cycle %0d: got %b, required %b", cyc, cfg_ready, m_rdy && !m_pv);
        end
        for (int i = 0; i < NCH; i++) begin
          ntests++;
          if (clk_out[i] !== m_ck[i]) begin
            nfail++;
            $display("FAIL clk_out_level ch%0d cycle %0d: got %b, required %b", i, cyc, clk_out[i], m_ck[i]);
          end
        end
        rdy_prev = ready;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_send(input int ch, input int dv);
    int b;
    cfg_ch    = CH_W'(ch);
    cfg_div   = DIV_W'(dv);
    cfg_valid = 1'b1;
    b = 0;
    while (cfg_ready !== 1'b1 && b < 200) begin
      idle(1);
      b++;
    end
    ntests++;
    if (b >= 200) begin
      nfail++;
      $display("FAIL cfg_handshake ch%0d: cfg_ready got 0 for %0d cycles, required 1", ch, b);
    end
    idle(1);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_tick(input int ch);
    int b;
    b = 0;
    while (tick[ch] !== 1'b1 && b < 50) begin
      idle(1);
      b++;
    end
    ntests++;
    if (b >= 50) begin
      nfail++;
      $display("FAIL wait_tick ch%0d: tick got 0 for %0d cycles, required 1", ch, b);
    end
  endtask

  initial begin
    cfg_req_t r;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(40);

    cfg_send(0, 4);  idle(40);
    cfg_send(1, 4);  idle(20);
    wait_tick(1);    idle(1);
    cfg_send(1, 6);  idle(40);
    cfg_send(2, 0);  idle(10);
    cfg_send(2, 1);  idle(10);
    cfg_send(2, 3);  idle(10);
    cfg_send(5, 9);  idle(5);
    cfg_send(7, 1);  idle(5);
    ch_enable[3] = 1'b0; idle(3);
    cfg_send(3, 5);  idle(3);
    ch_enable[3] = 1'b1; idle(20);
    cfg_send(1, 6);  idle(20);

    for (int k = 0; k < 40; k++) begin
      r.ch  = CH_W'($urandom_range(0, 7));
      r.div = DIV_W'($urandom_range(0, 9));
      if ($urandom_range(0, 2) == 0) ch_enable = NCH'($urandom_range(0, 15));
      cfg_send(int'(r.ch), int'(r.div));
      idle(int'($urandom_range(0, 15)));
    end

    ch_enable = '1;
    cfg_send(0, 20); idle(45);
    cfg_send(0, 3);  idle(2);
    #1 rst_n = 1'b0;
    #0.2;
    ntests++;
    if (tick !== '0 || clk_out !== '0 || ready !== 1'b0 || cfg_ready !== 1'b0) begin
      nfail++;
      $display("FAIL async_reset: tick=%b clk_out=%b ready=%b cfg_ready=%b, required all zero",
               tick, clk_out, ready, cfg_ready);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(60);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1);
  end

endmodule
